// File: rtl/spi_bus_arbiter_if.sv
// Bundle of requester-side and spi_master-side signals around the SPI bus arbiter.
// The arbiter takes the slave view; requesters plus the spi_master take the master view.
interface spi_bus_arbiter_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_last;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         rsp_data;
  logic [N_REQ-1:0]   rsp_valid;
  logic [7:0]         m_tx_data;
  logic               m_tx_valid;
  logic               m_tx_done;
  logic [7:0]         m_rx_data;
  logic               m_rx_valid;
  logic [N_REQ-1:0]   cs_n;
  logic               busy;
  logic               timeout;

  modport slave (
    input  req_valid, req_last, req_data, m_tx_done, m_rx_data, m_rx_valid,
    output req_ready, rsp_data, rsp_valid, m_tx_data, m_tx_valid, cs_n, busy, timeout
  );

  modport master (
    output req_valid, req_last, req_data, m_tx_done, m_rx_data, m_rx_valid,
    input  req_ready, rsp_data, rsp_valid, m_tx_data, m_tx_valid, cs_n, busy, timeout
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one spi_master between N_REQ requesters, one chip select each.
// A grant covers a whole burst; cs_n stays low from setup through hold.
module spi_bus_arbiter #(
  parameter int N_REQ        = 2,
  parameter int CS_SETUP     = 2,
  parameter int CS_HOLD      = 2,
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstn,
  spi_bus_arbiter_if.slave  bus
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_ISSUE, ST_XFER, ST_WAITNEXT, ST_HOLD
  } state_t;

  state_t           state_reg, state_next;
  logic [15:0]      cnt_reg, cnt_next;
  logic [GW-1:0]    grant_reg, grant_next;
  logic [GW-1:0]    ptr_reg, ptr_next;
  logic             last_reg, last_next;
  logic [N_REQ-1:0] cs_n_reg, cs_n_next;
  logic [7:0]       rsp_data_reg, rsp_data_next;
  logic [N_REQ-1:0] rsp_valid_reg, rsp_valid_next;

  logic [7:0]         req_byte [N_REQ];
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [GW-1:0]      pick_off;
  logic [GW:0]        pick_sum;
  logic [GW-1:0]      pick_idx;
  logic [N_REQ-1:0]   pick_oh;
  logic [N_REQ-1:0]   grant_oh;
  logic               grant_valid;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign req_byte[gi] = bus.req_data[8*gi +: 8];
    end
  endgenerate

  // Rotate requests so bit 0 is the pointer position; lowest set bit wins.
  assign req_dbl = {bus.req_valid, bus.req_valid};
  assign req_rot = req_dbl[ptr_reg +: N_REQ];

  always_comb begin
    pick_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) pick_off = GW'(k);
    end
  end

  assign pick_sum    = {1'b0, ptr_reg} + {1'b0, pick_off};
  assign pick_idx    = (pick_sum >= (GW+1)'(N_REQ)) ? GW'(pick_sum - (GW+1)'(N_REQ))
                                                    : pick_sum[GW-1:0];
  assign pick_oh     = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
  assign grant_oh    = {{(N_REQ-1){1'b0}}, 1'b1} << grant_reg;
  assign grant_valid = bus.req_valid[grant_reg];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      grant_reg     <= '0;
      ptr_reg       <= '0;
      last_reg      <= 1'b0;
      cs_n_reg      <= '1;
      rsp_data_reg  <= '0;
      rsp_valid_reg <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      grant_reg     <= grant_next;
      ptr_reg       <= ptr_next;
      last_reg      <= last_next;
      cs_n_reg      <= cs_n_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_valid_reg <= rsp_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    grant_next     = grant_reg;
    ptr_next       = ptr_reg;
    last_next      = last_reg;
    cs_n_next      = cs_n_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_valid_next = '0;

    // Receive path runs independently of the tx_done decision in the same cycle.
    if (state_reg == ST_XFER && bus.m_rx_valid) begin
      rsp_data_next  = bus.m_rx_data;
      rsp_valid_next = grant_oh;
    end

    case (state_reg)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          grant_next = pick_idx;
          cs_n_next  = ~pick_oh;
          cnt_next   = '0;
          state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_reg == 16'(CS_SETUP - 1)) begin
          cnt_next   = '0;
          state_next = ST_ISSUE;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      ST_ISSUE: begin
        last_next  = bus.req_last[grant_reg];
        state_next = ST_XFER;
      end
      ST_XFER: begin
        if (bus.m_tx_done) begin
          cnt_next = '0;
          if (last_reg)         state_next = ST_HOLD;
          else if (grant_valid) state_next = ST_ISSUE;
          else                  state_next = ST_WAITNEXT;
        end
      end
      ST_WAITNEXT: begin
        if (grant_valid) begin
          cnt_next   = '0;
          state_next = ST_ISSUE;
        end else if (cnt_reg == 16'(IDLE_TIMEOUT - 1)) begin
          cnt_next   = '0;
          state_next = ST_HOLD;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_reg == 16'(CS_HOLD - 1)) begin
          cnt_next   = '0;
          cs_n_next  = '1;
          ptr_next   = (grant_reg == GW'(N_REQ - 1)) ? '0 : grant_reg + 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.m_tx_valid = 1'b0;
    bus.m_tx_data  = '0;
    bus.req_ready  = '0;
    bus.timeout    = 1'b0;
    bus.busy       = (state_reg != ST_IDLE);
    if (state_reg == ST_ISSUE) begin
      bus.m_tx_valid = 1'b1;
      bus.m_tx_data  = req_byte[grant_reg];
      bus.req_ready  = grant_oh;
    end
    if (state_reg == ST_WAITNEXT && !grant_valid && cnt_reg == 16'(IDLE_TIMEOUT - 1))
      bus.timeout = 1'b1;
  end

  assign bus.cs_n      = cs_n_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_valid = rsp_valid_reg;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: requester queues, a fixed-latency spi_master echo
// model (rx = tx ^ 0x99) and an event recorder feeding hand-computed expectations.
module tb_spi_bus_arbiter;
  localparam int N   = 2;
  localparam int SU  = 2;
  localparam int HD  = 2;
  localparam int IT  = 8;
  localparam int LAT = 3;

  logic clk;
  logic rstn;

  spi_bus_arbiter_if #(.N_REQ(N)) bus ();

  spi_bus_arbiter #(.N_REQ(N), .CS_SETUP(SU), .CS_HOLD(HD), .IDLE_TIMEOUT(IT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("  ok %s = %0h", tag, got);
    end
  endtask

  logic [8:0] rq0[$];
  logic [8:0] rq1[$];
  logic [9:0] tx_q[$];
  logic [9:0] rsp_q[$];
  logic [1:0] rdy_q[$];
  int setup_q[$], gap_q[$], own_q[$], hold_q[$], to_q[$];

  int cyc, cs_low_cnt, gap_cnt, since_done, since_to, done_cyc, owner, mcnt;
  bit prev_low, done_seen, to_seen, rx_early, low;
  logic [7:0] pend;

  // Environment: sample on negedge, drive 1 time unit after posedge.
  initial begin
    bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0;
    bus.m_tx_done = 1'b0; bus.m_rx_valid = 1'b0; bus.m_rx_data = '0;
    cyc = 0; mcnt = 0; prev_low = 0; done_seen = 0; to_seen = 0;
    cs_low_cnt = 0; gap_cnt = 0; since_done = 0; since_to = 0; done_cyc = 0; owner = 0;
    pend = '0; rx_early = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        prev_low = 0; done_seen = 0; to_seen = 0; cs_low_cnt = 0; gap_cnt = 0; mcnt = 0;
      end else begin
        low = (bus.cs_n != 2'b11);
        if (low && done_seen) since_done++;
        if (low && to_seen) since_to++;
        if (low && !prev_low) begin
          gap_q.push_back(gap_cnt);
          cs_low_cnt = 0;
          owner = bus.cs_n[0] ? 1 : 0;
        end
        if (bus.m_tx_valid) begin
          tx_q.push_back({bus.cs_n, bus.m_tx_data});
          setup_q.push_back(cs_low_cnt);
          mcnt = LAT;
          pend = bus.m_tx_data;
        end
        if (low) cs_low_cnt++;
        if (bus.m_tx_done && low) begin done_seen = 1; since_done = 0; done_cyc = cyc; end
        if (bus.timeout) begin to_seen = 1; since_to = 0; to_q.push_back(cyc - done_cyc); end
        if (bus.rsp_valid != '0) rsp_q.push_back({bus.rsp_valid, bus.rsp_data});
        if (bus.req_ready != '0) rdy_q.push_back(bus.req_ready);
        if (bus.req_ready[0] && rq0.size() > 0) void'(rq0.pop_front());
        if (bus.req_ready[1] && rq1.size() > 0) void'(rq1.pop_front());
        if (!low && prev_low) begin
          own_q.push_back(owner);
          hold_q.push_back(to_seen ? since_to : since_done);
          done_seen = 0; to_seen = 0; gap_cnt = 0;
        end
        if (!low) gap_cnt++;
        prev_low = low;
      end
      @(posedge clk);
      #1;
      bus.req_valid[0] = (rq0.size() != 0);
      if (rq0.size() != 0) {bus.req_last[0], bus.req_data[7:0]} = rq0[0];
      bus.req_valid[1] = (rq1.size() != 0);
      if (rq1.size() != 0) {bus.req_last[1], bus.req_data[15:8]} = rq1[0];
      bus.m_tx_done  = 1'b0;
      bus.m_rx_valid = 1'b0;
      if (rstn && mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          bus.m_tx_done = 1'b1;
          if (!rx_early) begin bus.m_rx_valid = 1'b1; bus.m_rx_data = pend ^ 8'h99; end
        end else if (mcnt == 1 && rx_early) begin
          bus.m_rx_valid = 1'b1;
          bus.m_rx_data  = pend ^ 8'h99;
        end
      end
    end
  end

  task automatic clear_log();
    tx_q.delete(); rsp_q.delete(); rdy_q.delete();
    setup_q.delete(); gap_q.delete(); own_q.delete(); hold_q.delete(); to_q.delete();
  endtask

  task automatic wait_bursts(input string tag, input int n);
    int k = 0;
    while (own_q.size() < n && k < 300) begin
      @(negedge clk); #1; k++;
    end
    chk(tag, own_q.size(), n);
  endtask

  logic [7:0] exp3 [6];
  int         own3 [4];

  initial begin
    exp3 = '{8'h10, 8'h11, 8'h20, 8'h12, 8'h21, 8'h22};
    own3 = '{0, 1, 0, 1};
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #1;
    chk("rst_cs_n", bus.cs_n, 2'b11);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_req_ready", bus.req_ready, 2'b00);
    chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
    chk("rst_rsp_data", bus.rsp_data, 8'h00);
    chk("rst_tx_valid", bus.m_tx_valid, 1'b0);
    chk("rst_tx_data", bus.m_tx_data, 8'h00);
    chk("rst_timeout", bus.timeout, 1'b0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk); #1;

    // single byte from requester 0, rx coincident with tx_done
    clear_log();
    rx_early = 0;
    rq0.push_back({1'b1, 8'hA5});
    wait_bursts("t1_bursts", 1);
    chk("t1_tx_count", tx_q.size(), 1);
    chk("t1_tx", tx_q[0], {2'b10, 8'hA5});
    chk("t1_setup", setup_q[0], SU);
    chk("t1_rsp", rsp_q[0], {2'b01, 8'h3C});
    chk("t1_ready", rdy_q[0], 2'b01);
    chk("t1_owner", own_q[0], 0);
    chk("t1_hold", hold_q[0], HD);

    // three-byte burst from requester 1, rx a cycle ahead of tx_done
    clear_log();
    rx_early = 1;
    rq1.push_back({1'b0, 8'h01});
    rq1.push_back({1'b0, 8'h02});
    rq1.push_back({1'b1, 8'h03});
    wait_bursts("t2_bursts", 1);
    chk("t2_tx_count", tx_q.size(), 3);
    chk("t2_rsp_count", rsp_q.size(), 3);
    chk("t2_ready_count", rdy_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2_tx%0d", i), tx_q[i], {2'b01, 8'(i + 1)});
      chk($sformatf("t2_rsp%0d", i), rsp_q[i], {2'b10, 8'(i + 1) ^ 8'h99});
      chk($sformatf("t2_ready%0d", i), rdy_q[i], 2'b10);
    end
    chk("t2_setup", setup_q[0], SU);
    chk("t2_hold", hold_q[0], HD);
    chk("t2_owner", own_q[0], 1);

    // contention: both requesters hold two bursts each
    clear_log();
    rx_early = 0;
    rq0.push_back({1'b0, 8'h10}); rq0.push_back({1'b1, 8'h11}); rq0.push_back({1'b1, 8'h12});
    rq1.push_back({1'b1, 8'h20}); rq1.push_back({1'b0, 8'h21}); rq1.push_back({1'b1, 8'h22});
    wait_bursts("t3_bursts", 4);
    chk("t3_tx_count", tx_q.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t3_tx%0d", i), tx_q[i][7:0], exp3[i]);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_owner%0d", i), own_q[i], own3[i]);
      chk($sformatf("t3_gap%0d", i), 32'(gap_q[i] >= 1), 1);
    end

    // stall: non-last byte then nothing -> timeout
    clear_log();
    rq0.push_back({1'b0, 8'h55});
    wait_bursts("t4_bursts", 1);
    chk("t4_timeouts", to_q.size(), 1);
    chk("t4_to_delay", to_q[0], IT);
    chk("t4_hold", hold_q[0], HD);
    chk("t4_owner", own_q[0], 0);
    chk("t4_rsp", rsp_q[0], {2'b01, 8'hCC});

    // reset while requester 1 is mid-transfer; pointer must restart at 0
    clear_log();
    rq1.push_back({1'b1, 8'h77});
    begin
      int k = 0;
      while (tx_q.size() < 1 && k < 100) begin @(negedge clk); #1; k++; end
    end
    chk("t5_tx_seen", tx_q.size(), 1);
    @(posedge clk); #2;
    chk("t5_busy_pre", bus.busy, 1'b1);
    rstn = 1'b0;
    #1;
    chk("t5_cs_n", bus.cs_n, 2'b11);
    chk("t5_busy", bus.busy, 1'b0);
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    @(negedge clk); #1;
    clear_log();
    rq0.push_back({1'b1, 8'h31});
    rq1.push_back({1'b1, 8'h41});
    wait_bursts("t5_bursts", 2);
    chk("t5_owner0", own_q[0], 0);
    chk("t5_owner1", own_q[1], 1);
    chk("t5_tx0", tx_q[0], {2'b10, 8'h31});
    chk("t5_tx1", tx_q[1], {2'b01, 8'h41});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end
endmodule
